// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Definitions shared by the pipeline latches and the hazard/forwarding logic.
//   - CTRL_* : bit positions inside the packed control word
//              {mem_to_reg, mem_write, mem_read, reg_write, alu_src}
//   - NOP_OPCODE / NOP_FUNCT : an all-zero op/funct decodes as SLL r0 (a NOP)
//   - NB_REG_DEF / NB_CTRL_DEF : default widths of register index and control
// -----------------------------------------------------------------------------
package pipeline_pkg;

    localparam int NB_REG_DEF  = 5;
    localparam int NB_CTRL_DEF = 5;

    localparam int CTRL_ALU_SRC    = 0;
    localparam int CTRL_REG_WRITE  = 1;
    localparam int CTRL_MEM_READ   = 2;
    localparam int CTRL_MEM_WRITE  = 3;
    localparam int CTRL_MEM_TO_REG = 4;

    localparam logic [5:0] NOP_OPCODE = 6'h00;
    localparam logic [5:0] NOP_FUNCT  = 6'h00;

endpackage

// File: rtl/id_ex_latch_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that stops at all-ones instead of wrapping.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low clear
//   i_en     : count enable (one increment per enabled edge)
//   o_count  : current count, W bits
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count_p1;
    logic         w_at_max;

    assign w_at_max = &r_count_p1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count_p1 <= '0;
        end else if (i_en && !w_at_max) begin
            r_count_p1 <= r_count_p1 + 1'b1;
        end
    end

    assign o_count = r_count_p1;

endmodule

// File: rtl/id_ex_latch.sv
// -----------------------------------------------------------------------------
// id_ex_latch
// Decode -> execute pipeline register. Captures operands, immediate,
// opcode/funct, rt/rd and packed control bits; supports debug freeze
// (i_step=0), branch flush and load-use bubble insertion.
//
// Optional feature macro: ID_EX_BUBBLE_COUNT_EN
//   When defined, adds o_bubble_count: saturating count of bubbles inserted
//   since reset (held while frozen).
//
// Ports:
//   i_clk, i_rst_n      : clock (rising), asynchronous active-low reset
//   i_step              : advance enable; 0 holds every register
//   i_flush, i_bubble   : either one loads a bubble (all fields zero)
//   i_valid             : decode slot holds a real instruction
//   i_data_a/b, i_immediate, i_funct_code, i_op_code, i_rt, i_rd, i_ctrl
//                       : decoded fields to capture
//   o_*                 : registered copies of the above
//   o_bubble_count      : (macro only) bubbles inserted, saturating
// -----------------------------------------------------------------------------
module id_ex_latch
    import pipeline_pkg::*;
#(
    parameter int NB        = 32,
    parameter int NB_FCODE  = 6,
    parameter int NB_OPCODE = 6,
    parameter int NB_REG    = NB_REG_DEF,
    parameter int NB_CTRL   = NB_CTRL_DEF,
    parameter int NB_BCNT   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_step,
    input  logic                 i_flush,
    input  logic                 i_bubble,
    input  logic                 i_valid,
    input  logic [NB-1:0]        i_data_a,
    input  logic [NB-1:0]        i_data_b,
    input  logic [NB-1:0]        i_immediate,
    input  logic [NB_FCODE-1:0]  i_funct_code,
    input  logic [NB_OPCODE-1:0] i_op_code,
    input  logic [NB_REG-1:0]    i_rt,
    input  logic [NB_REG-1:0]    i_rd,
    input  logic [NB_CTRL-1:0]   i_ctrl,
`ifdef ID_EX_BUBBLE_COUNT_EN
    output logic [NB_BCNT-1:0]   o_bubble_count,
`endif
    output logic                 o_valid,
    output logic [NB-1:0]        o_data_a,
    output logic [NB-1:0]        o_data_b,
    output logic [NB-1:0]        o_immediate,
    output logic [NB_FCODE-1:0]  o_funct_code,
    output logic [NB_OPCODE-1:0] o_op_code,
    output logic [NB_REG-1:0]    o_rt,
    output logic [NB_REG-1:0]    o_rd,
    output logic [NB_CTRL-1:0]   o_ctrl
);

    logic                 r_valid_p1;
    logic [NB-1:0]        r_data_a_p1;
    logic [NB-1:0]        r_data_b_p1;
    logic [NB-1:0]        r_immediate_p1;
    logic [NB_FCODE-1:0]  r_funct_code_p1;
    logic [NB_OPCODE-1:0] r_op_code_p1;
    logic [NB_REG-1:0]    r_rt_p1;
    logic [NB_REG-1:0]    r_rd_p1;
    logic [NB_CTRL-1:0]   r_ctrl_p1;

    // Flush and bubble collapse to the same single-bubble request.
    logic w_kill;
    assign w_kill = i_flush | i_bubble;

    // ---- decode -> execute boundary ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid_p1      <= 1'b0;
            r_data_a_p1     <= '0;
            r_data_b_p1     <= '0;
            r_immediate_p1  <= '0;
            r_funct_code_p1 <= NB_FCODE'(NOP_FUNCT);
            r_op_code_p1    <= NB_OPCODE'(NOP_OPCODE);
            r_rt_p1         <= '0;
            r_rd_p1         <= '0;
            r_ctrl_p1       <= '0;
        end else if (i_step) begin
            if (w_kill) begin
                // Bubble: zero op/funct is SLL r0, and zero ctrl makes
                // sure nothing downstream writes registers or memory.
                r_valid_p1      <= 1'b0;
                r_data_a_p1     <= '0;
                r_data_b_p1     <= '0;
                r_immediate_p1  <= '0;
                r_funct_code_p1 <= NB_FCODE'(NOP_FUNCT);
                r_op_code_p1    <= NB_OPCODE'(NOP_OPCODE);
                r_rt_p1         <= '0;
                r_rd_p1         <= '0;
                r_ctrl_p1       <= '0;
            end else begin
                r_valid_p1      <= i_valid;
                r_data_a_p1     <= i_data_a;
                r_data_b_p1     <= i_data_b;
                r_immediate_p1  <= i_immediate;
                r_funct_code_p1 <= i_funct_code;
                r_op_code_p1    <= i_op_code;
                r_rt_p1         <= i_rt;
                r_rd_p1         <= i_rd;
                // An empty decode slot still passes its data through, but
                // must not carry any side-effecting control.
                r_ctrl_p1       <= i_valid ? i_ctrl : '0;
            end
        end
    end

    assign o_valid      = r_valid_p1;
    assign o_data_a     = r_data_a_p1;
    assign o_data_b     = r_data_b_p1;
    assign o_immediate  = r_immediate_p1;
    assign o_funct_code = r_funct_code_p1;
    assign o_op_code    = r_op_code_p1;
    assign o_rt         = r_rt_p1;
    assign o_rd         = r_rd_p1;
    assign o_ctrl       = r_ctrl_p1;

`ifdef ID_EX_BUBBLE_COUNT_EN
    logic w_bubble_inc;
    assign w_bubble_inc = i_step & w_kill;

    sat_counter #(
        .W (NB_BCNT)
    ) u_bubble_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_bubble_inc),
        .o_count (o_bubble_count)
    );
`endif

endmodule
